// File: rtl/mmap_pkg.sv
// mmap_pkg: shared definitions for the mmap_dma copy engine.
//   - FSM state encoding (also visible on the top-level debug port)
//   - descriptor word indices in source memory
//   - control-word bit positions
//   - completion status word field offsets
package mmap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_COPY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_STAT  = 3'd4,
    ST_REARM = 3'd5
  } state_e;

  // Descriptor word indices (source word addresses)
  localparam int unsigned DESC_CTRL = 0;
  localparam int unsigned DESC_SRC  = 1;
  localparam int unsigned DESC_DST  = 2;
  localparam int unsigned DESC_LEN  = 3;

  // Control word bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_MODE  = 1;

  // Status word fields
  localparam int unsigned STAT_DONE      = 0;
  localparam int unsigned STAT_MODE      = 1;
  localparam int unsigned STAT_COUNT_LSB = 16;

endpackage

// File: rtl/mmap_rd_pipe.sv
// mmap_rd_pipe: RD_LAT-deep delay line that carries a valid flag and the
// destination address of each issued source read, so both emerge in the same
// cycle the read data returns from the source memory.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-low reset
//   i_valid        a read is issued this cycle
//   i_addr         destination address paired with that read
//   o_valid        read data for a tracked read is on i_data this cycle
//   o_addr         destination address paired with that data
// Handshake: valid-only, no ready. The source memory never stalls, so an
// issued read always returns exactly RD_LAT cycles later.
module mmap_rd_pipe #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= i_valid;
      addr_q[0] <= i_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign o_valid = vld_q[RD_LAT-1];
  assign o_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/mmap_dma.sv
// mmap_dma: descriptor-driven memory-to-memory copy engine.
// Fetches a 4-word descriptor from source address 0, streams LEN words from
// SRC to DST one per cycle (optionally swapping halves), writes a status word
// at STATUS_ADDR, then waits for the START bit to be cleared before re-arming.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-low reset
//   o_addr0        source word address
//   i_data         source read data, RD_LAT cycles behind o_addr0
//   o_addr1        destination word address
//   o_we           destination write enable
//   o_data         destination write data
//   o_busy         engine is between descriptor fetch and re-arm
//   o_done         one-cycle pulse with the status write
//   o_dbg_state    current FSM state (mmap_pkg::state_e encoding)
module mmap_dma
  import mmap_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned STATUS_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_addr0,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_addr1,
  output logic              o_we,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, wr_cnt_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              mode_q, wr_we_q;

  logic              settled;
  logic [ADDR_W-1:0] hdr_ret;
  logic              issue;
  logic [ADDR_W-1:0] issue_dst;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] status;

  // In IDLE/REARM the counter saturates at RD_LAT: from then on i_data shows
  // word 0 as read in this state, not a leftover from an earlier address.
  assign settled = (cnt_q >= ADDR_W'(RD_LAT));
  // Descriptor word index whose read data is on i_data this HDR cycle.
  assign hdr_ret = cnt_q - ADDR_W'(RD_LAT) + ADDR_W'(DESC_SRC);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt restarts at 0 on every state change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (settled && i_data[CTRL_START]) state_d = ST_HDR;
      ST_HDR:   if (hdr_ret == ADDR_W'(DESC_LEN))
                  state_d = (i_data[ADDR_W-1:0] == '0) ? ST_STAT : ST_COPY;
      ST_COPY:  if (cnt_q == len_q - ADDR_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == ADDR_W'(RD_LAT)) state_d = ST_STAT;
      ST_STAT:  state_d = ST_REARM;
      ST_REARM: if (settled && !i_data[CTRL_START]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == ST_IDLE || state_q == ST_REARM) && settled)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + ADDR_W'(1);
  end

  // Output logic
  always_comb begin
    o_addr0   = ADDR_W'(DESC_CTRL);
    issue     = 1'b0;
    issue_dst = dst_q + cnt_q;
    case (state_q)
      ST_HDR:  if (cnt_q < ADDR_W'(3)) o_addr0 = ADDR_W'(DESC_SRC) + cnt_q;
      ST_COPY: begin
        o_addr0 = src_q + cnt_q;
        issue   = 1'b1;
      end
      default: o_addr0 = ADDR_W'(DESC_CTRL);
    endcase

    status                              = '0;
    status[STAT_DONE]                   = 1'b1;
    status[STAT_MODE]                   = mode_q;
    status[STAT_COUNT_LSB +: ADDR_W]    = wr_cnt_q;

    o_done      = (state_q == ST_STAT);
    o_we        = wr_we_q || o_done;
    o_addr1     = o_done ? ADDR_W'(STATUS_ADDR) : wr_addr_q;
    o_data      = o_done ? status : wr_data_q;
    o_busy      = (state_q != ST_IDLE);
    o_dbg_state = state_q;
  end

  mmap_rd_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (issue),
    .i_addr  (issue_dst),
    .o_valid (pipe_valid),
    .o_addr  (pipe_addr)
  );

  // Descriptor capture and registered write stage
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      wr_we_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_HDR) mode_q <= i_data[CTRL_MODE];

      if (state_q == ST_HDR) begin
        if (hdr_ret == ADDR_W'(DESC_SRC)) src_q <= i_data[ADDR_W-1:0];
        if (hdr_ret == ADDR_W'(DESC_DST)) dst_q <= i_data[ADDR_W-1:0];
        if (hdr_ret == ADDR_W'(DESC_LEN)) len_q <= i_data[ADDR_W-1:0];
      end

      if (state_q == ST_IDLE)  wr_cnt_q <= '0;
      else if (wr_we_q)        wr_cnt_q <= wr_cnt_q + ADDR_W'(1);

      wr_we_q   <= pipe_valid;
      wr_addr_q <= pipe_valid ? pipe_addr : '0;
      if (!pipe_valid)
        wr_data_q <= '0;
      else if (mode_q)
        wr_data_q <= {i_data[DATA_W/2-1:0], i_data[DATA_W-1:DATA_W/2]};
      else
        wr_data_q <= i_data;
    end
  end

endmodule

// File: tb/tb_mmap_dma.sv
// tb_mmap_dma: directed bench for mmap_dma. Two instances run side by side,
// one with RD_LAT=1 and one with RD_LAT=3, fed from one shared source memory
// through per-instance read-latency models. A negedge monitor logs every
// destination write per instance; directed tests then compare the log with
// hand-computed expectations.
module tb_mmap_dma;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int N_INST = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n   [N_INST];
  logic [ADDR_W-1:0] addr0_w [N_INST];
  logic [DATA_W-1:0] rdata_w [N_INST];
  logic [ADDR_W-1:0] addr1_w [N_INST];
  logic              we_w    [N_INST];
  logic [DATA_W-1:0] data_w  [N_INST];
  logic              busy_w  [N_INST];
  logic              done_w  [N_INST];
  logic [2:0]        state_w [N_INST];

  mmap_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .STATUS_ADDR(0)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst_n[0]), .o_addr0(addr0_w[0]), .i_data(rdata_w[0]),
    .o_addr1(addr1_w[0]), .o_we(we_w[0]), .o_data(data_w[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0]), .o_dbg_state(state_w[0]));

  mmap_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .STATUS_ADDR(0)) u_dut_l3 (
    .i_clk(clk), .i_rst(rst_n[1]), .o_addr0(addr0_w[1]), .i_data(rdata_w[1]),
    .o_addr1(addr1_w[1]), .o_we(we_w[1]), .o_data(data_w[1]), .o_busy(busy_w[1]),
    .o_done(done_w[1]), .o_dbg_state(state_w[1]));

  // ---------------- source memory model ----------------
  logic [DATA_W-1:0] src_mem [DEPTH];
  logic [ADDR_W-1:0] rd_q [N_INST][3];

  always @(posedge clk) begin
    for (int g = 0; g < N_INST; g++) begin
      rd_q[g][0] <= addr0_w[g];
      rd_q[g][1] <= rd_q[g][0];
      rd_q[g][2] <= rd_q[g][1];
    end
  end

  always_comb begin
    rdata_w[0] = src_mem[rd_q[0][0]];
    rdata_w[1] = src_mem[rd_q[1][2]];
  end

  // ---------------- write monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              log_clr = 1'b0;
  int                h_cyc     [N_INST];
  int                first_cyc [N_INST];
  int                last_cyc  [N_INST];
  int                stat_cyc  [N_INST];
  int                n_data    [N_INST];
  int                n_stat    [N_INST];
  int                n_done    [N_INST];
  logic [DATA_W-1:0] stat_data [N_INST];
  logic [ADDR_W-1:0] stat_addr [N_INST];
  logic              busy_prev [N_INST];
  logic [DATA_W-1:0] dst_mem   [N_INST][DEPTH];

  always @(negedge clk) begin
    for (int g = 0; g < N_INST; g++) begin
      if (log_clr) begin
        h_cyc[g] = 0; first_cyc[g] = 0; last_cyc[g] = 0; stat_cyc[g] = 0;
        n_data[g] = 0; n_stat[g] = 0; n_done[g] = 0;
        stat_data[g] = '0; stat_addr[g] = '0;
      end else begin
        if (busy_w[g] && !busy_prev[g]) h_cyc[g] = cyc;
        if (done_w[g]) n_done[g]++;
        if (we_w[g] && done_w[g]) begin
          n_stat[g]++;
          stat_data[g] = data_w[g];
          stat_addr[g] = addr1_w[g];
          stat_cyc[g]  = cyc;
        end else if (we_w[g]) begin
          if (n_data[g] == 0) first_cyc[g] = cyc;
          last_cyc[g] = cyc;
          n_data[g]++;
          dst_mem[g][addr1_w[g]] = data_w[g];
        end
      end
      busy_prev[g] = busy_w[g];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_status(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      ok = (n_stat[0] != 0) && (n_stat[1] != 0);
    end
    check_eq("status_timeout", 32'(ok), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_desc(input logic [31:0] ctrl, input logic [31:0] src,
                          input logic [31:0] dst, input logic [31:0] len);
    log_clr = 1'b1;
    @(negedge clk); #1;
    log_clr = 1'b0;
    src_mem[1] = src;
    src_mem[2] = dst;
    src_mem[3] = len;
    src_mem[0] = ctrl;
    wait_status(200);
  endtask

  task automatic finish_desc(input string name);
    bit ok = 1'b0;
    src_mem[0] = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !busy_w[0] && !busy_w[1];
    end
    check_eq({name, "_rearm_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic check_run(input int g, input string name, input int len,
                           input int first_off, input int stat_off, input logic [31:0] exp_stat);
    string t = $sformatf("%s_lat%0d", name, (g == 0) ? 1 : 3);
    check_eq({t, "_ndata"},     32'(n_data[g]), 32'(len));
    check_eq({t, "_nstat"},     32'(n_stat[g]), 32'd1);
    check_eq({t, "_ndone"},     32'(n_done[g]), 32'd1);
    check_eq({t, "_stat_addr"}, 32'(stat_addr[g]), 32'd0);
    check_eq({t, "_stat_data"}, stat_data[g], exp_stat);
    check_eq({t, "_stat_time"}, 32'(stat_cyc[g] - h_cyc[g]), 32'(stat_off));
    if (len > 0) begin
      check_eq({t, "_first_time"}, 32'(first_cyc[g] - h_cyc[g]), 32'(first_off));
      check_eq({t, "_back2back"},  32'(last_cyc[g] - first_cyc[g]), 32'(len - 1));
    end
  endtask

  // ---------------- directed tests ----------------
  int first_off [N_INST] = '{6, 10};

  initial begin
    logic [DATA_W-1:0] a_vals [4];
    logic [DATA_W-1:0] d_vals [8];
    int                h;
    bit                ok;

    a_vals = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3};
    for (int k = 0; k < 8; k++) d_vals[k] = 32'hD000_0000 + 32'(k) * 32'h0001_0001;
    for (int i = 0; i < DEPTH; i++) src_mem[i] = '0;

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #2;
    for (int g = 0; g < N_INST; g++) begin
      check_eq($sformatf("reset_addr0_%0d", g), 32'(addr0_w[g]), 32'd0);
      check_eq($sformatf("reset_addr1_%0d", g), 32'(addr1_w[g]), 32'd0);
      check_eq($sformatf("reset_we_%0d", g),    32'(we_w[g]),    32'd0);
      check_eq($sformatf("reset_data_%0d", g),  data_w[g],       32'd0);
      check_eq($sformatf("reset_busy_%0d", g),  32'(busy_w[g]),  32'd0);
      check_eq($sformatf("reset_done_%0d", g),  32'(done_w[g]),  32'd0);
      check_eq($sformatf("reset_state_%0d", g), 32'(state_w[g]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (4) @(posedge clk);

    // Basic copy: 4 words 8..11 -> 100..103
    for (int k = 0; k < 4; k++) src_mem[8+k] = a_vals[k];
    run_desc(32'd1, 32'd8, 32'd100, 32'd4);
    check_run(0, "basic", 4, first_off[0], 10, 32'h0004_0001);
    check_run(1, "basic", 4, first_off[1], 14, 32'h0004_0001);
    for (int g = 0; g < N_INST; g++)
      for (int k = 0; k < 4; k++)
        check_eq($sformatf("basic_data_%0d_%0d", g, k), dst_mem[g][100+k], a_vals[k]);
    // START left set: engine must park in REARM without a second run
    repeat (30) @(posedge clk);
    #1;
    for (int g = 0; g < N_INST; g++) begin
      check_eq($sformatf("no_retrigger_done_%0d", g), 32'(n_done[g]), 32'd1);
      check_eq($sformatf("no_retrigger_busy_%0d", g), 32'(busy_w[g]), 32'd1);
      check_eq($sformatf("no_retrigger_state_%0d", g), 32'(state_w[g]), 32'd5);
    end
    finish_desc("basic");

    // Swap mode, single word
    src_mem[8] = 32'h1234_5678;
    run_desc(32'd3, 32'd8, 32'd50, 32'd1);
    check_run(0, "swap", 1, first_off[0], 7, 32'h0001_0003);
    check_run(1, "swap", 1, first_off[1], 11, 32'h0001_0003);
    check_eq("swap_data_0", dst_mem[0][50], 32'h5678_1234);
    check_eq("swap_data_1", dst_mem[1][50], 32'h5678_1234);
    finish_desc("swap");

    // Zero length: status only
    run_desc(32'd1, 32'd8, 32'd60, 32'd0);
    check_run(0, "len0", 0, 0, 4, 32'h0000_0001);
    check_run(1, "len0", 0, 0, 6, 32'h0000_0001);
    finish_desc("len0");

    // Address wrap: reads 1022,1023,0 ; writes 1023,0,1
    src_mem[1022] = 32'hAAAA_5555;
    src_mem[1023] = 32'h0F0F_F0F0;
    run_desc(32'd1, 32'd1022, 32'd1023, 32'd3);
    check_run(0, "wrap", 3, first_off[0], 9, 32'h0003_0001);
    check_run(1, "wrap", 3, first_off[1], 13, 32'h0003_0001);
    for (int g = 0; g < N_INST; g++) begin
      check_eq($sformatf("wrap_d1023_%0d", g), dst_mem[g][1023], 32'hAAAA_5555);
      check_eq($sformatf("wrap_d0_%0d", g),    dst_mem[g][0],    32'h0F0F_F0F0);
      check_eq($sformatf("wrap_d1_%0d", g),    dst_mem[g][1],    32'h0000_0001);
    end
    finish_desc("wrap");

    // Eight-word burst
    for (int k = 0; k < 8; k++) src_mem[16+k] = d_vals[k];
    run_desc(32'd1, 32'd16, 32'd300, 32'd8);
    check_run(0, "len8", 8, first_off[0], 14, 32'h0008_0001);
    check_run(1, "len8", 8, first_off[1], 18, 32'h0008_0001);
    for (int g = 0; g < N_INST; g++)
      for (int k = 0; k < 8; k++)
        check_eq($sformatf("len8_data_%0d_%0d", g, k), dst_mem[g][300+k], d_vals[k]);
    finish_desc("len8");

    // Abort the RD_LAT=1 instance during its third write; the other runs on
    log_clr = 1'b1;
    @(negedge clk); #1;
    log_clr = 1'b0;
    src_mem[1] = 32'd16;
    src_mem[2] = 32'd400;
    src_mem[3] = 32'd8;
    src_mem[0] = 32'd1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = busy_w[0];
    end
    check_eq("abort_start", 32'(ok), 32'd1);
    h = cyc;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (cyc == h + 8);
    end
    check_eq("abort_third_we",   32'(we_w[0]),    32'd1);
    check_eq("abort_third_addr", 32'(addr1_w[0]), 32'd402);
    rst_n[0] = 1'b0;
    #1;
    check_eq("abort_we_drop", 32'(we_w[0]),    32'd0);
    check_eq("abort_state",   32'(state_w[0]), 32'd0);
    check_eq("abort_busy",    32'(busy_w[0]),  32'd0);
    src_mem[2] = 32'd500;
    src_mem[3] = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_no_status", 32'(n_stat[0]), 32'd0);
    check_eq("abort_no_done",   32'(n_done[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    wait_status(200);
    check_eq("abort_rerun_ndata", 32'(n_data[0]), 32'd4);
    check_eq("abort_rerun_nstat", 32'(n_stat[0]), 32'd1);
    check_eq("abort_rerun_stat",  stat_data[0],   32'h0002_0001);
    check_eq("abort_rerun_time",  32'(stat_cyc[0] - h_cyc[0]), 32'd8);
    check_eq("abort_d400", dst_mem[0][400], d_vals[0]);
    check_eq("abort_d401", dst_mem[0][401], d_vals[1]);
    check_eq("abort_d402_unwritten", dst_mem[0][402], 32'd0);
    check_eq("abort_d500", dst_mem[0][500], d_vals[0]);
    check_eq("abort_d501", dst_mem[0][501], d_vals[1]);
    check_run(1, "abort_peer", 8, first_off[1], 18, 32'h0008_0001);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("abort_peer_data_%0d", k), dst_mem[1][400+k], d_vals[k]);
    finish_desc("abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
